// File: rtl/stream_capture.sv
// Sample capture FIFO that frames each full payload into a byte-wise packet
// (SYNC, DEST, LEN, then samples high byte first) over a valid/ready handshake.
module stream_capture #(
  parameter int unsigned DEPTH_LOG2      = 9,
  parameter int unsigned PAYLOAD_SAMPLES = 64,
  parameter logic [7:0]  SYNC_BYTE       = 8'h55,
  parameter logic [7:0]  DEST_BYTE       = 8'h02
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  input  logic                  ipEnable,
  input  logic [15:0]           ipSample,
  input  logic                  ipSampleValid,
  output logic [7:0]            opTxData,
  output logic                  opTxValid,
  output logic                  opTxSOP,
  output logic                  opTxEOP,
  input  logic                  ipTxReady,
  output logic [DEPTH_LOG2:0]   opFIFO_Size,
  output logic [15:0]           opOverflowCount
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned SCNT_W = 7;

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  PAY_CNT  = CNT_W'(PAYLOAD_SAMPLES);
  localparam logic [SCNT_W-1:0] LAST_SMP = SCNT_W'(PAYLOAD_SAMPLES - 1);
  localparam logic [7:0]        LEN_BYTE = 8'(2 * PAYLOAD_SAMPLES);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DEST,
    LEN,
    DATA_HI,
    DATA_LO
  } state_t;

  state_t state, state_next;

  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [SCNT_W-1:0] smp_cnt, smp_cnt_next;
  logic [7:0]        data_next;
  logic              valid_next, sop_next, eop_next;
  logic              full, wr_en, drop, pop, handshake;
  logic [15:0]       head;
  logic [7:0]        head_next_hi;

  // Occupancy is taken at the start of the cycle, so a pop never frees room for a same-cycle write.
  assign full         = (opFIFO_Size == FULL_CNT);
  assign wr_en        = ipEnable & ipSampleValid & ~full;
  assign drop         = ipEnable & ipSampleValid & full;
  assign handshake    = opTxValid & ipTxReady;
  assign head         = mem[rd_ptr];
  assign head_next_hi = mem[rd_ptr + PTR_W'(1)][15:8];

  always_ff @(posedge ipClk) begin
    if (wr_en) begin
      mem[wr_ptr] <= ipSample;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      opFIFO_Size     <= '0;
      opOverflowCount <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !pop) begin
        opFIFO_Size <= opFIFO_Size + CNT_W'(1);
      end else if (!wr_en && pop) begin
        opFIFO_Size <= opFIFO_Size - CNT_W'(1);
      end
      if (drop && (opOverflowCount != 16'hFFFF)) begin
        opOverflowCount <= opOverflowCount + 16'd1;
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      opTxData  <= '0;
      opTxValid <= 1'b0;
      opTxSOP   <= 1'b0;
      opTxEOP   <= 1'b0;
    end else begin
      state     <= state_next;
      smp_cnt   <= smp_cnt_next;
      opTxData  <= data_next;
      opTxValid <= valid_next;
      opTxSOP   <= sop_next;
      opTxEOP   <= eop_next;
    end
  end

  // Next-state and next-output logic; outputs hold unless a byte transfers.
  always_comb begin
    state_next   = state;
    smp_cnt_next = smp_cnt;
    data_next    = opTxData;
    valid_next   = opTxValid;
    sop_next     = opTxSOP;
    eop_next     = opTxEOP;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (opFIFO_Size >= PAY_CNT) begin
          state_next = SYNC;
          valid_next = 1'b1;
          data_next  = SYNC_BYTE;
          sop_next   = 1'b1;
          eop_next   = 1'b0;
        end
      end
      SYNC: begin
        if (handshake) begin
          state_next = DEST;
          data_next  = DEST_BYTE;
          sop_next   = 1'b0;
        end
      end
      DEST: begin
        if (handshake) begin
          state_next = LEN;
          data_next  = LEN_BYTE;
        end
      end
      LEN: begin
        if (handshake) begin
          state_next   = DATA_HI;
          data_next    = head[15:8];
          smp_cnt_next = '0;
        end
      end
      DATA_HI: begin
        if (handshake) begin
          state_next = DATA_LO;
          data_next  = head[7:0];
          eop_next   = (smp_cnt == LAST_SMP);
        end
      end
      DATA_LO: begin
        if (handshake) begin
          pop      = 1'b1;
          eop_next = 1'b0;
          if (smp_cnt == LAST_SMP) begin
            state_next = IDLE;
            valid_next = 1'b0;
            data_next  = '0;
          end else begin
            state_next   = DATA_HI;
            data_next    = head_next_hi;
            smp_cnt_next = smp_cnt + SCNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        sop_next   = 1'b0;
        eop_next   = 1'b0;
      end
    endcase
  end

endmodule
